// File: rtl/reg_serializer.sv
// Parallel-in, serial-out register reader: captures D on START and shifts it out LSB first
// over a valid/ready serial port. Optional even-parity trailer beat when REG_SER_PARITY_EN is defined.
module reg_serializer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] D,
  output logic             SOUT,
  output logic             SVALID,
  input  logic             SREADY,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       state_dbg
);

`ifdef REG_SER_PARITY_EN
  localparam int BEATS = WIDTH + 1;
`else
  localparam int BEATS = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BEATS-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BEATS-1:0]   load_word;

  // Parity rides in the top bit of the shift register so it falls out as the last beat.
`ifdef REG_SER_PARITY_EN
  assign load_word = {^D, D};
`else
  assign load_word = D;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake: a beat transfers on a rising CLK edge where SVALID=1 and SREADY=1.
  // While SVALID=1 and SREADY=0, SOUT and all internal state are held unchanged.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          shreg_d = load_word;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (SREADY) begin
          shreg_d = {1'b0, shreg_q[BEATS-1:1]};
          if (cnt_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs decode from registered state only.
  assign SVALID    = (state_q == S_SHIFT);
  assign SOUT      = SVALID & shreg_q[0];
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = (state_q == S_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_reg_serializer.sv
// Randomized and directed bench for reg_serializer: beat-level reference model feeds an
// expected-bit queue that a negedge monitor drains and compares against the serial port.
`timescale 1ns/1ps
module tb_reg_serializer;
  localparam int WIDTH = 32;
`ifdef REG_SER_PARITY_EN
  localparam int BEATS = WIDTH + 1;
`else
  localparam int BEATS = WIDTH;
`endif
  localparam int BUDGET = 4 * BEATS + 40;

  logic             CLK = 1'b0;
  logic             RST;
  logic             START;
  logic [WIDTH-1:0] D;
  logic             SOUT;
  logic             SVALID;
  logic             SREADY;
  logic             BUSY;
  logic             DONE;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:0]       exp_q[$];
  int               m_beats = 0;
  bit               m_done  = 1'b0;
  logic [BEATS-1:0] rx_word;
  int               rx_n;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  reg_serializer #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .D         (D),
    .SOUT      (SOUT),
    .SVALID    (SVALID),
    .SREADY    (SREADY),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .state_dbg (state_dbg)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Counts remaining beats of the word in flight; a capture pushes the whole expected stream.
  initial begin
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        exp_q.delete();
        m_beats = 0;
        m_done  = 1'b0;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (m_beats > 0) begin
        if (SREADY) begin
          m_beats--;
          if (m_beats == 0) m_done = 1'b1;
        end
      end else if (START) begin
        for (int i = 0; i < WIDTH; i++) exp_q.push_back(D[i]);
`ifdef REG_SER_PARITY_EN
        exp_q.push_back(^D);
`endif
        m_beats = BEATS;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge CLK);
      check("svalid", 64'(SVALID), 64'(m_beats > 0));
      check("busy",   64'(BUSY),   64'((m_beats > 0) || m_done));
      check("done",   64'(DONE),   64'(m_done));
      if (m_beats > 0 && SVALID) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sout_underflow: got %0b, expected no beat (t=%0t)", SOUT, $time);
        end else begin
          check("sout", 64'(SOUT), 64'(exp_q[0]));
          if (SREADY) begin
            void'(exp_q.pop_front());
            if (rx_n < BEATS) rx_word[rx_n] = SOUT;
            rx_n++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      START  = 1'b0;
      SREADY = 1'($urandom_range(0, 1));
      D      = $urandom;
    end
  endtask

  // mode 0: SREADY=1; 1: random SREADY/START/D; 2: START held, D forced to all-ones at cycle 10;
  // mode 3: SREADY=0 for three cycles at bit 5, then toggling.
  task automatic run_word(input logic [WIDTH-1:0] d, input int mode);
    int j, ones, stalls, done_at;
    bit r;
    @(posedge CLK); #1;
    D = d; START = 1'b1; SREADY = 1'b1;
    rx_n = 0; rx_word = '0;
    ones = 0; stalls = 0; done_at = -1; j = 0;
    while (j < BUDGET) begin
      @(posedge CLK); #1;
      j++;
      case (mode)
        1: begin
          START = 1'($urandom_range(0, 1));
          D     = $urandom;
          r     = ($urandom_range(0, 3) != 0);
        end
        2: begin
          START = 1'b1;
          if (j == 10) D = '1;
          r = 1'b1;
        end
        3: begin
          START = 1'b0;
          D     = $urandom;
          r     = (j <= 5) ? 1'b1 : (j <= 8) ? 1'b0 : (((j - 9) % 2) == 0);
        end
        default: begin
          START = 1'b0;
          D     = $urandom;
          r     = 1'b1;
        end
      endcase
      SREADY = r;
      if (ones < BEATS) begin
        if (r) ones++;
        else stalls++;
      end
      @(negedge CLK);
      if (DONE) begin
        done_at = j;
        break;
      end
    end
    if (done_at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no DONE in %0d cycles, expected at cycle %0d", BUDGET, BEATS + 1 + stalls);
    end else begin
      check("done_cycle", 64'(done_at), 64'(BEATS + 1 + stalls));
    end
    check("rx_count", 64'(rx_n), 64'(BEATS));
    check("rx_word",  64'(rx_word[WIDTH-1:0]), 64'(d));
`ifdef REG_SER_PARITY_EN
    check("rx_parity", 64'(rx_word[WIDTH]), 64'(^d));
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1; START = 1'b0; SREADY = 1'b0; D = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_sout",   64'(SOUT),   64'd0);
    check("rst_svalid", 64'(SVALID), 64'd0);
    check("rst_busy",   64'(BUSY),   64'd0);
    check("rst_done",   64'(DONE),   64'd0);
    RST = 1'b0;
    idle_cycles(2);

    run_word(32'hA5A5_0001, 0);
    check("basic_stream", 64'(rx_word[WIDTH-1:0]), 64'h0000_0000_A5A5_0001);
    idle_cycles(1);
    run_word(32'hA5A5_0001, 3);
    idle_cycles(2);

    // START held through SHIFT/DONE: next capture lands on the first IDLE edge, taking all-ones.
    run_word(32'h1234_5678, 2);
    run_word(32'hFFFF_FFFF, 0);
    idle_cycles(2);

    // Async reset after bit 10 has been accepted.
    @(posedge CLK); #1;
    D = 32'hDEAD_BEEF; START = 1'b1; SREADY = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (11) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check("mid_rst_sout",   64'(SOUT),   64'd0);
    check("mid_rst_svalid", 64'(SVALID), 64'd0);
    check("mid_rst_busy",   64'(BUSY),   64'd0);
    check("mid_rst_done",   64'(DONE),   64'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    idle_cycles(2);
    run_word(32'h0000_0003, 0);
    check("post_rst_bits", 64'(rx_word[2:0]), 64'd3);

`ifdef REG_SER_PARITY_EN
    idle_cycles(1);
    run_word(32'h0000_0007, 0);
    check("parity_of_7", 64'(rx_word[WIDTH]), 64'd1);
    idle_cycles(1);
    run_word(32'h0000_0003, 0);
    check("parity_of_3", 64'(rx_word[WIDTH]), 64'd0);
`endif

    for (int n = 0; n < 25; n++) begin
      idle_cycles($urandom_range(0, 3));
      run_word($urandom, ($urandom_range(0, 3) == 0) ? 0 : 1);
    end

    idle_cycles(3);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
